uart_tx_param: RTL and testbench
================================

# uart_tx_param

Parametrised UART transmitter core: a write-side FIFO of configurable depth feeding a frame serialiser with 5–8 data bits, none/odd/even parity, 1 or 2 stop bits and a line-break generator. It sits between the CPU bus write strobe and the TxD pin, driven by the shared oversampling baud tick. It adds FIFO level reporting, a sticky overflow flag and a transmit-complete flag.

## Interface
Parameters:
- DEPTH, 16 — FIFO entries; power of two, at least 2.
- OSR, 16 — Baud_tick pulses per bit time; at least 1.

Ports:
- CLK50MHZ  in  1  — single clock; all logic on the rising edge.
- rst  in  1  — reset, synchronous and active-high.
- Baud_tick  in  1  — one-cycle pulse at OSR × baud rate.
- D_num  in  2  — data bits per frame: 00=5, 01=6, 10=7, 11=8.
- S_num  in  1  — stop bits: 0=1, 1=2.
- Par  in  2  — parity: 00=none, 01=odd, 10=even, 11=treated as none.
- DATA  in  8  — character to enqueue; the LSB is sent first.
- n_WR  in  1  — active-low write strobe; one entry per cycle while low.
- C_nD  in  1  — 0=data write; 1=configuration, ignored by this block.
- brk  in  1  — level-sensitive break request.
- TxD  out  1  — serial line; idles at 1.
- Tx_RDY  out  1  — FIFO can accept a character (= not full).
- Tx_EMPTY  out  1  — FIFO empty and serialiser idle.
- Tx_level  out  $clog2(DEPTH)+1  — current FIFO occupancy.
- Tx_ovf  out  1  — sticky flag: a write was dropped because the FIFO was full.

## Operation
- Write: `wr = ~n_WR & ~C_nD`.
  - If wr and not full, DATA is stored.
  - If wr and full, the write is dropped and Tx_ovf is set. Only rst clears Tx_ovf.
  - A pop in the same cycle does not free a slot for that write.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK. A tick counter `tcnt` (0..OSR-1) advances on Baud_tick; a bit ends on the Baud_tick where tcnt==OSR-1.
- IDLE
  - brk=1 → BREAK. brk has priority over pending data.
  - Otherwise, if the FIFO is not empty: pop one entry, latch the data byte and D_num/S_num/Par into the frame registers, clear tcnt, go to START.
  - Configuration inputs are sampled only here; changes mid-frame do not affect the frame in progress.
- START: TxD=0 for one bit time → DATA with bit index 0.
- DATA: TxD = data[idx]. After each bit time, idx increments. After bit D−1 (D = 5..8): go to PARITY if parity is enabled, else STOP.
- PARITY
  - even: TxD = XOR of the D data bits.
  - odd: TxD = its inverse.
  - Bits above D−1 are excluded from the parity calculation.
- STOP: TxD=1 for S bit times (S = 1 or 2) → IDLE.
  - The next frame's START can begin on the cycle after the stop period ends.
- BREAK: TxD=0 for as long as brk=1, with a minimum of one bit time. After brk falls, the FSM enters STOP with one stop bit (mark), then returns to IDLE.
- Frame length in ticks = OSR × (1 + D + P + S). Example: 8N1 → 10·OSR.

## Timing
- Reset values: TxD=1, Tx_RDY=1, Tx_EMPTY=1, Tx_level=0, Tx_ovf=0, FSM=IDLE.
- Registers: FIFO pointers, level and FSM state.
- Reset mid-frame: TxD=1 from the next cycle. The FIFO is flushed and any partial frame is abandoned.
- Write at cycle n → Tx_level increments at n+1.
- If the block is idle, the pop happens at n+1 and TxD falls at n+2. The start bit lasts until OSR Baud_ticks have been counted, beginning at n+2.
- Pop and write in the same cycle (FIFO not full) → Tx_level unchanged.
- Tx_RDY and Tx_EMPTY are combinational from registered state; they have no extra lag beyond Tx_level.
- Tx_EMPTY drops the cycle after the first accepted write. It rises the cycle after the last stop bit ends with the FIFO empty.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full is defined as level==DEPTH.

## Structure
- Package `uart_pkg`:
  - FSM state enum.
  - Par encodings (PAR_NONE/ODD/EVEN/INV).
  - D_num→bit-count function.
  - S_num encoding.
- Sub-module `uart_sync_fifo`: parametrised DEPTH × 8, synchronous reset, with push, pop, full, empty and level outputs.
- The serialiser FSM, tick counter and bit index live in the top module.

## Test plan
- OSR=1, Baud_tick tied to 1, 8N1. Write 0xA5 → TxD = 0,1,0,1,0,0,1,0,1,1 (one cycle per bit), then Tx_EMPTY=1.
- 7 bits, even parity, 2 stop bits. Write 0x7F → seven 1s, parity bit 1, two stop bits. Repeat with odd parity → parity bit 0. Par=11 → no parity bit.
- DEPTH=4. Hold n_WR low for 6 cycles while idle → 5 accepted (one is popped immediately), Tx_ovf=1, Tx_RDY=0 while full. Then four frames are sent in order.
- Change D_num mid-frame → current frame keeps its latched length; the next frame uses the new value.
- Assert brk for 3 bit times while data is queued → TxD held low 3 bit times, then one mark bit, then the queued frame.
- Assert rst in the middle of the DATA state → next cycle: TxD=1, Tx_level=0, Tx_EMPTY=1, Tx_ovf=0.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the parametrised UART transmitter.
//   tx_state_t  - serialiser FSM states
//   PAR_*       - encodings of the Par input
//   STOP_*      - encodings of the S_num input
//   frame_t     - per-frame settings latched when a character leaves the FIFO
//   data_bits() - D_num -> number of data bits (5..8)
//   make_frame()- builds the latched frame settings from a character + config
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_BREAK  = 3'd5
   } tx_state_t;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_ODD  = 2'b01;
   localparam logic [1:0] PAR_EVEN = 2'b10;
   localparam logic [1:0] PAR_INV  = 2'b11;  // behaves like PAR_NONE

   localparam logic STOP_1 = 1'b0;
   localparam logic STOP_2 = 1'b1;

   typedef struct packed {
      logic [7:0] data;      // character, LSB transmitted first
      logic [2:0] last_idx;  // index of the final data bit (D-1)
      logic       par_en;    // a parity bit follows the data bits
      logic       par_bit;   // precomputed parity bit value
      logic       two_stop;  // two stop bits instead of one
   } frame_t;

   function automatic logic [3:0] data_bits(input logic [1:0] d_num);
      return 4'd5 + {2'b00, d_num};
   endfunction

   // Even parity is the XOR of the D transmitted bits; the bits above D-1
   // are masked off so they cannot influence the result.
   function automatic logic parity_bit(input logic [7:0] data,
                                       input logic [1:0] d_num,
                                       input logic [1:0] par);
      logic [7:0] mask;
      logic       x;
      mask = 8'hFF >> (2'd3 - d_num);
      x    = ^(data & mask);
      return (par == PAR_ODD) ? ~x : x;
   endfunction

   function automatic frame_t make_frame(input logic [7:0] data,
                                         input logic [1:0] d_num,
                                         input logic       s_num,
                                         input logic [1:0] par);
      frame_t f;
      f.data     = data;
      f.last_idx = 3'(data_bits(d_num) - 4'd1);
      f.par_en   = (par == PAR_ODD) || (par == PAR_EVEN);
      f.par_bit  = parity_bit(data, d_num, par);
      f.two_stop = (s_num == STOP_2);
      return f;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
// Synchronous first-word-fall-through FIFO, DEPTH x WIDTH.
//   clk, rst  - rising-edge clock, synchronous active-high reset (flushes)
//   push      - write request; ignored while full (full is taken from the
//               registered level, so a same-cycle pop never frees the slot)
//   wdata     - data to store
//   pop       - read request; ignored while empty
//   rdata     - head entry, valid whenever empty is low
//   full      - level == DEPTH
//   empty     - level == 0
//   level     - current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module uart_sync_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW  = $clog2(DEPTH);
   localparam int LW  = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Storage needs no reset: an entry is only read after it was written.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers are AW bits wide and wrap modulo DEPTH (DEPTH is a power of two).
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_param.sv
// -----------------------------------------------------------------------------
// uart_tx_param
// UART transmitter: write FIFO feeding a frame serialiser (5..8 data bits,
// none/odd/even parity, 1 or 2 stop bits) with a line-break generator.
//   CLK50MHZ  - clock, all logic on the rising edge
//   rst       - synchronous active-high reset; flushes FIFO, abandons frame
//   Baud_tick - one-cycle pulse at OSR x baud rate
//   D_num     - data bits: 00=5, 01=6, 10=7, 11=8
//   S_num     - stop bits: 0=1, 1=2
//   Par       - parity: 00=none, 01=odd, 10=even, 11=none
//   DATA      - character to enqueue
//   n_WR      - active-low write strobe, one entry per cycle while low
//   C_nD      - 1 marks a configuration write, which this block ignores
//   brk       - level-sensitive break request
//   TxD       - serial output, idles high
//   Tx_RDY    - FIFO not full
//   Tx_EMPTY  - FIFO empty and serialiser idle
//   Tx_level  - FIFO occupancy
//   Tx_ovf    - sticky: a write was dropped because the FIFO was full
//
// Handshakes: on the write side wr (= ~n_WR & ~C_nD) is the valid and Tx_RDY
// is the ready; a character transfers on a rising edge where both are high.
// A valid without ready is not held off: the character is dropped and Tx_ovf
// is set. On the FIFO read side the serialiser raises pop only in IDLE with
// the FIFO non-empty, and the head entry is consumed on that same edge.
// -----------------------------------------------------------------------------
module uart_tx_param
   import uart_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int OSR   = 16
) (
   input  logic                     CLK50MHZ,
   input  logic                     rst,
   input  logic                     Baud_tick,
   input  logic [1:0]               D_num,
   input  logic                     S_num,
   input  logic [1:0]               Par,
   input  logic [7:0]               DATA,
   input  logic                     n_WR,
   input  logic                     C_nD,
   input  logic                     brk,
   output logic                     TxD,
   output logic                     Tx_RDY,
   output logic                     Tx_EMPTY,
   output logic [$clog2(DEPTH):0]   Tx_level,
   output logic                     Tx_ovf
);

   localparam int TW = (OSR > 1) ? $clog2(OSR) : 1;

   logic       wr;
   logic       fifo_pop;
   logic [7:0] fifo_rdata;
   logic       fifo_full;
   logic       fifo_empty;

   tx_state_t  state, state_n;
   logic [TW-1:0] tcnt, tcnt_n;
   logic [2:0] bit_idx, bit_idx_n;
   logic       stop_cnt, stop_cnt_n;   // stop bits already completed
   logic       brk_min, brk_min_n;     // break has lasted one full bit time
   logic       bit_end;
   logic       load;                   // latch a new frame from the FIFO head
   logic       brk_go;                 // entering BREAK from IDLE
   logic       txd_c;
   frame_t     frame;

   assign wr = ~n_WR & ~C_nD;

   uart_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk   (CLK50MHZ),
      .rst   (rst),
      .push  (wr),
      .wdata (DATA),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (Tx_level)
   );

   assign bit_end = Baud_tick && (tcnt == TW'(OSR - 1));

   // Next-state and line decode.
   always_comb begin
      state_n    = state;
      tcnt_n     = tcnt;
      bit_idx_n  = bit_idx;
      stop_cnt_n = stop_cnt;
      brk_min_n  = brk_min;
      fifo_pop   = 1'b0;
      load       = 1'b0;
      brk_go     = 1'b0;
      txd_c      = 1'b1;

      if (state != ST_IDLE && Baud_tick) begin
         tcnt_n = bit_end ? '0 : tcnt + TW'(1);
      end

      case (state)
         ST_IDLE: begin
            tcnt_n = '0;
            if (brk) begin
               brk_go    = 1'b1;
               brk_min_n = 1'b0;
               state_n   = ST_BREAK;
            end else if (!fifo_empty) begin
               fifo_pop = 1'b1;
               load     = 1'b1;
               state_n  = ST_START;
            end
         end

         ST_START: begin
            txd_c = 1'b0;
            if (bit_end) begin
               bit_idx_n = '0;
               state_n   = ST_DATA;
            end
         end

         ST_DATA: begin
            txd_c = frame.data[bit_idx];
            if (bit_end) begin
               if (bit_idx == frame.last_idx) begin
                  stop_cnt_n = 1'b0;
                  state_n    = frame.par_en ? ST_PARITY : ST_STOP;
               end else begin
                  bit_idx_n = bit_idx + 3'd1;
               end
            end
         end

         ST_PARITY: begin
            txd_c = frame.par_bit;
            if (bit_end) begin
               stop_cnt_n = 1'b0;
               state_n    = ST_STOP;
            end
         end

         ST_STOP: begin
            txd_c = 1'b1;
            if (bit_end) begin
               if (frame.two_stop && !stop_cnt) begin
                  stop_cnt_n = 1'b1;
               end else begin
                  state_n = ST_IDLE;
               end
            end
         end

         ST_BREAK: begin
            txd_c = 1'b0;
            if (bit_end) begin
               brk_min_n = 1'b1;
            end
            // brk may fall mid-bit; the mark bit that follows always gets a
            // full bit time, so the tick counter restarts here.
            if (!brk && (brk_min || bit_end)) begin
               tcnt_n     = '0;
               stop_cnt_n = 1'b0;
               state_n    = ST_STOP;
            end
         end

         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK50MHZ) begin
      if (rst) begin
         state    <= ST_IDLE;
         tcnt     <= '0;
         bit_idx  <= '0;
         stop_cnt <= 1'b0;
         brk_min  <= 1'b0;
         frame    <= '0;
         Tx_ovf   <= 1'b0;
      end else begin
         state    <= state_n;
         tcnt     <= tcnt_n;
         bit_idx  <= bit_idx_n;
         stop_cnt <= stop_cnt_n;
         brk_min  <= brk_min_n;
         // Configuration is captured only when a frame starts, so mid-frame
         // changes apply to the next character.
         if (load) begin
            frame <= make_frame(fifo_rdata, D_num, S_num, Par);
         end else if (brk_go) begin
            frame.two_stop <= 1'b0;  // break always ends with a single mark
         end
         if (wr && fifo_full) begin
            Tx_ovf <= 1'b1;
         end
      end
   end

   assign TxD      = txd_c;
   assign Tx_RDY   = ~fifo_full;
   assign Tx_EMPTY = fifo_empty && (state == ST_IDLE);

endmodule

// File: tb/tb_uart_tx_param.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_param
// Bench for uart_tx_param with DEPTH=4, OSR=4 and a Baud_tick every 3 clocks
// (12 clocks per bit). Expected frames are written out by hand as bit strings
// in transmission order and pushed into exp_q before the character is written;
// a receiver process detects each start bit, samples mid-bit and compares.
// -----------------------------------------------------------------------------
module tb_uart_tx_param;

   localparam int DEPTH = 4;
   localparam int OSR   = 4;
   localparam int LW    = $clog2(DEPTH) + 1;
   localparam int BIT_CLKS = 12;

   logic          clk = 1'b0;
   logic          rst;
   logic          baud_tick;
   logic [1:0]    d_num;
   logic          s_num;
   logic [1:0]    par;
   logic [7:0]    data;
   logic          n_wr;
   logic          c_nd;
   logic          brk;
   logic          txd;
   logic          tx_rdy;
   logic          tx_empty;
   logic [LW-1:0] tx_level;
   logic          tx_ovf;

   int n_tests = 0;
   int n_fail  = 0;

   // {nbits[19:16], bits[15:0]}; bits right-aligned, first transmitted bit
   // is the most significant of the nbits.
   logic [19:0] exp_q[$];
   logic        mon_en;
   logic        mon_busy;
   int          tick_cnt;

   uart_tx_param #(
      .DEPTH (DEPTH),
      .OSR   (OSR)
   ) dut (
      .CLK50MHZ  (clk),
      .rst       (rst),
      .Baud_tick (baud_tick),
      .D_num     (d_num),
      .S_num     (s_num),
      .Par       (par),
      .DATA      (data),
      .n_WR      (n_wr),
      .C_nD      (c_nd),
      .brk       (brk),
      .TxD       (txd),
      .Tx_RDY    (tx_rdy),
      .Tx_EMPTY  (tx_empty),
      .Tx_level  (tx_level),
      .Tx_ovf    (tx_ovf)
   );

   // ---------------- clock / baud tick ----------------
   always #5 clk = ~clk;

   initial begin
      baud_tick = 1'b0;
      tick_cnt  = 0;
      forever begin
         @(negedge clk);
         tick_cnt  = (tick_cnt == 2) ? 0 : tick_cnt + 1;
         baud_tick = (tick_cnt == 0);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic expect_frame(input int nbits, input logic [15:0] bits);
      exp_q.push_back({4'(nbits), bits});
   endtask

   task automatic write_char(input logic [7:0] d);
      @(negedge clk);
      data = d;
      n_wr = 1'b0;
      @(negedge clk);
      n_wr = 1'b1;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int c;
      c = 0;
      while (!(tx_empty && exp_q.size() == 0 && !mon_busy) && c < budget) begin
         @(negedge clk);
         c++;
      end
      check(name, 32'(c < budget), 32'd1);
      repeat (4) @(negedge clk);
   endtask

   task automatic set_cfg(input logic [1:0] dn, input logic sn, input logic [1:0] pr);
      @(negedge clk);
      d_num = dn;
      s_num = sn;
      par   = pr;
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin : monitor
      logic [19:0] e;
      logic [15:0] got;
      int          nb;
      mon_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (mon_en && !rst && txd == 1'b0) begin
            mon_busy = 1'b1;
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_frame: start bit seen, expected queue empty");
               repeat (12 * BIT_CLKS) @(negedge clk);
            end else begin
               e   = exp_q.pop_front();
               nb  = int'(e[19:16]);
               got = '0;
               repeat (BIT_CLKS / 2 - 1) @(negedge clk);
               for (int k = 0; k < nb; k++) begin
                  if (k > 0) repeat (BIT_CLKS) @(negedge clk);
                  got = {got[14:0], txd};
               end
               check("frame_bits", {16'b0, got}, {16'b0, e[15:0]});
            end
            mon_busy = 1'b0;
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin : stim
      logic [7:0] ov_data [6];
      logic [9:0] ov_frame[5];
      int         ov_lvl  [6];
      int         low_cnt;

      ov_data  = '{8'h01, 8'h80, 8'h3C, 8'hC3, 8'h55, 8'hFF};
      ov_frame = '{10'b0100000001, 10'b0000000011, 10'b0001111001,
                   10'b0110000111, 10'b0101010101};
      ov_lvl   = '{1, 1, 2, 3, 4, 4};

      rst = 1'b1; n_wr = 1'b1; c_nd = 1'b0; brk = 1'b0;
      d_num = 2'b11; s_num = 1'b0; par = 2'b00; data = 8'h00;
      mon_en = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_txd",   32'(txd),      32'd1);
      check("reset_rdy",   32'(tx_rdy),   32'd1);
      check("reset_empty", 32'(tx_empty), 32'd1);
      check("reset_level", 32'(tx_level), 32'd0);
      check("reset_ovf",   32'(tx_ovf),   32'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // configuration write is ignored
      @(negedge clk); c_nd = 1'b1; n_wr = 1'b0;
      @(negedge clk); c_nd = 1'b0; n_wr = 1'b1;
      check("cnd_level", 32'(tx_level), 32'd0);
      check("cnd_empty", 32'(tx_empty), 32'd1);

      // 8N1 0xA5 with first-transaction timing
      expect_frame(10, 16'(10'b0101001011));
      write_char(8'hA5);
      check("wr_level_n1", 32'(tx_level), 32'd1);
      check("wr_txd_n1",   32'(txd),      32'd1);
      check("wr_empty_n1", 32'(tx_empty), 32'd0);
      @(negedge clk);
      check("pop_level_n2", 32'(tx_level), 32'd0);
      check("start_txd_n2", 32'(txd),      32'd0);
      wait_idle("drain_8n1", 400);
      check("idle_txd", 32'(txd), 32'd1);

      // 7 bits, 2 stop bits: even, odd, 11 (no parity)
      set_cfg(2'b10, 1'b1, 2'b10);
      expect_frame(11, 16'(11'b01111111111));
      write_char(8'h7F);
      wait_idle("drain_7e2", 400);
      set_cfg(2'b10, 1'b1, 2'b01);
      expect_frame(11, 16'(11'b01111111011));
      write_char(8'h7F);
      wait_idle("drain_7o2", 400);
      set_cfg(2'b10, 1'b1, 2'b11);
      expect_frame(10, 16'(10'b0111111111));
      write_char(8'h7F);
      wait_idle("drain_7x2", 400);

      // upper bits excluded from parity; 6-bit odd
      set_cfg(2'b00, 1'b0, 2'b10);
      expect_frame(8, 16'(8'b01100111));
      write_char(8'hF3);
      wait_idle("drain_5e1", 400);
      set_cfg(2'b01, 1'b0, 2'b01);
      expect_frame(9, 16'(9'b000110101));
      write_char(8'h2C);
      wait_idle("drain_6o1", 400);

      // overflow: n_WR low for 6 cycles while idle
      set_cfg(2'b11, 1'b0, 2'b00);
      for (int i = 0; i < 5; i++) expect_frame(10, 16'(ov_frame[i]));
      @(negedge clk);
      data = ov_data[0];
      n_wr = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("ovf_level", 32'(tx_level), 32'(ov_lvl[i]));
         if (i == 4) begin
            check("ovf_before_drop", 32'(tx_ovf), 32'd0);
            check("rdy_full",        32'(tx_rdy), 32'd0);
         end
         if (i < 5) data = ov_data[i+1];
         else       n_wr = 1'b1;
      end
      check("ovf_set",      32'(tx_ovf), 32'd1);
      check("rdy_still_0",  32'(tx_rdy), 32'd0);
      wait_idle("drain_ovf", 1200);
      check("ovf_sticky",   32'(tx_ovf), 32'd1);
      check("rdy_after",    32'(tx_rdy), 32'd1);

      // D_num change mid-frame applies to the next frame only
      expect_frame(10, 16'(10'b0111100001));
      expect_frame(7,  16'(7'b0011001));
      @(negedge clk); data = 8'h0F; n_wr = 1'b0;
      @(negedge clk); data = 8'hC6;
      @(negedge clk); n_wr = 1'b1;
      repeat (2) @(negedge clk);
      d_num = 2'b00;
      wait_idle("drain_dnum", 600);
      d_num = 2'b11;

      // break for 3 bit times with data queued
      expect_frame(4,  16'(4'b0001));
      expect_frame(10, 16'(10'b0010110101));
      @(negedge clk); brk = 1'b1;
      @(negedge clk); data = 8'h5A; n_wr = 1'b0;
      @(negedge clk); n_wr = 1'b1;
      repeat (20) @(negedge clk);
      check("brk_level", 32'(tx_level), 32'd1);
      check("brk_txd",   32'(txd),      32'd0);
      repeat (14) @(negedge clk);
      brk = 1'b0;
      wait_idle("drain_brk", 600);

      // reset in the middle of DATA
      mon_en = 1'b0;
      @(negedge clk); data = 8'h00; n_wr = 1'b0;
      @(negedge clk); data = 8'h11;
      @(negedge clk); data = 8'h22;
      @(negedge clk); n_wr = 1'b1;
      repeat (30) @(negedge clk);
      check("pre_rst_txd",   32'(txd),      32'd0);
      check("pre_rst_level", 32'(tx_level), 32'd2);
      rst = 1'b1;
      @(negedge clk);
      check("rst_txd",   32'(txd),      32'd1);
      check("rst_level", 32'(tx_level), 32'd0);
      check("rst_empty", 32'(tx_empty), 32'd1);
      check("rst_ovf",   32'(tx_ovf),   32'd0);
      check("rst_rdy",   32'(tx_rdy),   32'd1);
      rst = 1'b0;
      low_cnt = 0;
      repeat (60) begin
         @(negedge clk);
         if (txd == 1'b0) low_cnt++;
      end
      check("post_rst_line_idle", 32'(low_cnt),  32'd0);
      check("post_rst_empty",     32'(tx_empty), 32'd1);
      mon_en = 1'b1;

      check("exp_q_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
